// File: rtl/card_shoe_dealer_pkg.sv
// Shared sizes, FSM state type and card helpers for the card shoe dealer.
package card_shoe_dealer_pkg;

    localparam int CARD_W    = 4;
    localparam int RANK_W    = 4;
    localparam int NUM_RANKS = 13;
    localparam int DECK_SIZE = 52;
    localparam int COPIES    = 4;
    localparam int CNT_W     = 3;
    localparam int LEFT_W    = $clog2(DECK_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHUFFLE,
        PICK1,
        PICK2,
        DONE
    } shoe_state_t;

    function automatic logic [CARD_W-1:0] rank_to_value(input logic [RANK_W-1:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

    // Folds the low LFSR nibble (0..15) onto ranks 1..13.
    function automatic logic [RANK_W-1:0] lfsr_to_rank(input logic [15:0] lfsr);
        return ((lfsr[3:0] >= 4'd13) ? lfsr[3:0] - 4'd13 : lfsr[3:0]) + 4'd1;
    endfunction

    function automatic logic [RANK_W-1:0] next_rank(input logic [RANK_W-1:0] rank);
        return (rank == 4'd13) ? 4'd1 : rank + 4'd1;
    endfunction

endpackage

// File: rtl/card_shoe_dealer_if.sv
// Card-request path between the game controller (master) and the shoe dealer (slave).
interface card_shoe_dealer_if;
    import card_shoe_dealer_pkg::*;

    logic              draw_req;
    logic [2:0]        test_mode;
    logic [CARD_W-1:0] card1_out;
    logic [CARD_W-1:0] card2_out;
    logic              card_valid;
    logic              busy;
    logic              shuffling;
    logic [LEFT_W-1:0] cards_left;

    modport master (
        output draw_req, test_mode,
        input  card1_out, card2_out, card_valid, busy, shuffling, cards_left
    );

    modport slave (
        input  draw_req, test_mode,
        output card1_out, card2_out, card_valid, busy, shuffling, cards_left
    );

endinterface

// File: rtl/card_shoe_dealer_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, right-shifting; loads seed on reset.
module lfsr16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else if (en) begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/card_shoe_dealer.sv
// Deals two cards per request from a 52-card shoe without replacement, refilling when low.
//  state   | meaning
//  IDLE    | waiting for draw_req; outputs hold the last deal
//  SHUFFLE | restoring one rank count to full per cycle (13 cycles)
//  PICK1   | probing from the LFSR candidate for the first card
//  PICK2   | probing for the second card (or pairing with card1 in test_mode 7)
//  DONE    | card_valid pulse
module card_shoe_dealer
    import card_shoe_dealer_pkg::*;
#(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          RESHUFFLE_AT = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    card_shoe_dealer_if.slave bus
);

    localparam logic [LEFT_W-1:0] LOW_MARK  = LEFT_W'(RESHUFFLE_AT);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(COPIES);
    localparam logic [3:0]        LAST_SHUF = 4'(NUM_RANKS - 1);

    shoe_state_t       state, state_nx;
    logic [CNT_W-1:0]  rank_cnt [NUM_RANKS];
    logic [RANK_W-1:0] probe;
    logic [RANK_W-1:0] card1_rank;
    logic [RANK_W-1:0] cand_rank;
    logic [RANK_W-1:0] cur_rank;
    logic [RANK_W-1:0] idx;
    logic [CNT_W-1:0]  cur_cnt;
    logic              probing;
    logic              pick;
    logic              take;
    logic              force_pair;
    logic              lfsr_en;
    logic [3:0]        shuf_idx;
    logic [15:0]       lfsr_q;
    logic [LEFT_W-1:0] left_sum;
    logic [CARD_W-1:0] card1_q;
    logic [CARD_W-1:0] card2_q;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (lfsr_en),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    // Deterministic modes freeze the LFSR outside the pick states.
    assign pick       = (state == PICK1) || (state == PICK2);
    assign lfsr_en    = (bus.test_mode == 3'd0) || pick;
    assign cand_rank  = lfsr_to_rank(lfsr_q);
    assign force_pair = (state == PICK2) && (bus.test_mode == 3'd7) && !probing
                        && (rank_cnt[card1_rank - 4'd1] != '0);

    always_comb begin
        cur_rank = probing ? probe : cand_rank;
        if (force_pair) begin
            cur_rank = card1_rank;
        end
        idx     = cur_rank - 4'd1;
        cur_cnt = rank_cnt[idx];
    end

    assign take = pick && (cur_cnt != '0);

    always_comb begin
        left_sum = '0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            left_sum = left_sum + LEFT_W'(rank_cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        bus.busy       = 1'b1;
        bus.shuffling  = 1'b0;
        bus.card_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = bus.draw_req;
                if (bus.draw_req) begin
                    state_nx = (left_sum < LOW_MARK) ? SHUFFLE : PICK1;
                end
            end
            SHUFFLE: begin
                bus.shuffling = 1'b1;
                if (shuf_idx == LAST_SHUF) begin
                    state_nx = PICK1;
                end
            end
            PICK1: begin
                if (take) begin
                    state_nx = PICK2;
                end
            end
            PICK2: begin
                if (take) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.card_valid = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                rank_cnt[i] <= FULL_CNT;
            end
            probe      <= 4'd1;
            probing    <= 1'b0;
            shuf_idx   <= '0;
            card1_rank <= 4'd1;
            card1_q    <= '0;
            card2_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    shuf_idx <= '0;
                    probing  <= 1'b0;
                end
                SHUFFLE: begin
                    rank_cnt[shuf_idx] <= FULL_CNT;
                    shuf_idx           <= shuf_idx + 4'd1;
                end
                PICK1, PICK2: begin
                    if (take) begin
                        rank_cnt[idx] <= cur_cnt - 3'd1;
                        probing       <= 1'b0;
                        if (state == PICK1) begin
                            card1_q    <= rank_to_value(cur_rank);
                            card1_rank <= cur_rank;
                        end else begin
                            card2_q <= rank_to_value(cur_rank);
                        end
                    end else begin
                        probing <= 1'b1;
                        probe   <= next_rank(cur_rank);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.card1_out  = card1_q;
    assign bus.card2_out  = card2_q;
    assign bus.cards_left = left_sum;

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Self-checking bench for card_shoe_dealer against a shoe-level reference model.
module tb_card_shoe_dealer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    card_shoe_dealer_if bus();

    card_shoe_dealer #(
        .SEED         (16'hACE1),
        .RESHUFFLE_AT (12)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;
    logic [15:0] m_lfsr;
    int m_cnt [1:13];
    int tally [1:10];
    int last_c1, last_c2, last_shuf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic int cand(input logic [15:0] v);
        int n;
        n = int'(v[3:0]);
        return (n % 13) + 1;
    endfunction

    function automatic int val(input int r);
        return (r > 10) ? 10 : r;
    endfunction

    function automatic int model_left();
        int s = 0;
        for (int r = 1; r <= 13; r++) s += m_cnt[r];
        return s;
    endfunction

    task automatic clear_tally();
        for (int v = 1; v <= 10; v++) tally[v] = 0;
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        for (int r = 1; r <= 13; r++) m_cnt[r] = 4;
        clear_tally();
    endtask

    // One pick: n is the number of cycles spent, and the LFSR moves once per cycle.
    task automatic model_pick(input bit pair, input int r1, output int r, output int n);
        if (pair && m_cnt[r1] > 0) begin
            r = r1;
            n = 1;
        end else begin
            r = cand(m_lfsr);
            n = 1;
            while (m_cnt[r] == 0 && n < 14) begin
                r = (r % 13) + 1;
                n++;
            end
        end
        if (m_cnt[r] > 0) m_cnt[r]--;
        repeat (n) m_lfsr = lstep(m_lfsr);
    endtask

    task automatic do_reset(input logic [2:0] mode);
        bus.draw_req  = 1'b0;
        bus.test_mode = mode;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic tally_card(input string name, input int v);
        chk({name, "_range"}, int'(v >= 1 && v <= 10), 1);
        if (v >= 1 && v <= 10) begin
            tally[v]++;
            chk({name, "_over_deck"}, int'(tally[v] > ((v == 10) ? 16 : 4)), 0);
        end
    endtask

    task automatic run_deal(input logic [2:0] mode, input bit extra_req, input bit do_abort);
        int sh, n1, n2, r1, r2, lat, nshuf;
        bus.test_mode = mode;
        @(posedge clk); #1;
        bus.draw_req = 1'b1;
        @(negedge clk);
        chk("busy_on_req", int'(bus.busy), 1);
        sh = (model_left() < 12) ? 13 : 0;
        @(posedge clk); #1;
        if (mode == 3'd0) begin
            m_lfsr = 16'hACE1;
            repeat (edges) m_lfsr = lstep(m_lfsr);
        end
        if (sh != 0) begin
            for (int r = 1; r <= 13; r++) m_cnt[r] = 4;
            clear_tally();
            if (mode == 3'd0) repeat (13) m_lfsr = lstep(m_lfsr);
        end
        model_pick(1'b0, 0, r1, n1);
        model_pick(mode == 3'd7, r1, r2, n2);
        lat = 1 + sh + n1 + n2;
        nshuf = 0;
        for (int i = 1; i <= lat + 1; i++) begin
            bus.draw_req = extra_req && (i <= 2);
            @(negedge clk);
            nshuf += int'(bus.shuffling);
            chk("busy", int'(bus.busy), int'(i <= lat));
            chk("shuffling", int'(bus.shuffling), int'(i <= sh));
            chk("card_valid", int'(bus.card_valid), int'(i == lat));
            if (i == lat) begin
                last_c1 = int'(bus.card1_out);
                last_c2 = int'(bus.card2_out);
                chk("card1", last_c1, val(r1));
                chk("card2", last_c2, val(r2));
                chk("cards_left", int'(bus.cards_left), model_left());
                tally_card("card1", last_c1);
                tally_card("card2", last_c2);
            end
            if (do_abort && i == 1 + sh + n1) begin
                do_reset(mode);
                repeat (10) begin
                    @(negedge clk);
                    chk("abort_no_valid", int'(bus.card_valid), 0);
                    chk("abort_busy", int'(bus.busy), 0);
                    chk("abort_left", int'(bus.cards_left), 52);
                end
                chk("abort_card1", int'(bus.card1_out), 0);
                chk("abort_card2", int'(bus.card2_out), 0);
                return;
            end
            @(posedge clk); #1;
        end
        last_shuf = nshuf;
        if (extra_req) begin
            repeat (8) begin
                @(negedge clk);
                chk("dropped_req_valid", int'(bus.card_valid), 0);
                chk("dropped_req_busy", int'(bus.busy), 0);
            end
        end
    endtask

    initial begin
        bus.draw_req  = 1'b0;
        bus.test_mode = 3'd1;

        // Reset state
        do_reset(3'd1);
        repeat (5) @(negedge clk);
        chk("rst_cards_left", int'(bus.cards_left), 52);
        chk("rst_card_valid", int'(bus.card_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_shuffling", int'(bus.shuffling), 0);
        chk("rst_card1", int'(bus.card1_out), 0);
        chk("rst_card2", int'(bus.card2_out), 0);

        // Deterministic first deal from ACE1: ranks 2 then 1
        run_deal(3'd1, 1'b0, 1'b0);
        chk("t2_card1_lit", last_c1, 2);
        chk("t2_card2_lit", last_c2, 1);
        chk("t2_left_lit", int'(bus.cards_left), 50);
        do_reset(3'd1);
        run_deal(3'd1, 1'b0, 1'b0);
        chk("t2_repeat_card1", last_c1, 2);
        chk("t2_repeat_card2", last_c2, 1);

        // 26 requests: drain to 12, deal once more, then the refill
        do_reset(3'd1);
        for (int k = 0; k < 26; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_deal(3'd1, 1'b0, 1'b0);
            if (k == 19) chk("t4_left_at_12", int'(bus.cards_left), 12);
            if (k == 20) begin
                chk("t4_no_shuffle_at_12", last_shuf, 0);
                chk("t4_left_10", int'(bus.cards_left), 10);
            end
            if (k == 21) begin
                chk("t4_shuffle_cycles", last_shuf, 13);
                chk("t4_left_after_refill", int'(bus.cards_left), 50);
            end
        end

        // Forced pair from a full shoe
        do_reset(3'd7);
        run_deal(3'd7, 1'b0, 1'b0);
        chk("t5_pair", last_c1, last_c2);
        chk("t5_card_lit", last_c1, 2);
        chk("t5_rank_count", m_cnt[2], 2);
        chk("t5_left", int'(bus.cards_left), 50);

        // Requests while busy are dropped; reset mid-PICK2 aborts the deal
        do_reset(3'd1);
        run_deal(3'd1, 1'b1, 1'b0);
        run_deal(3'd1, 1'b0, 1'b1);

        // Free-running LFSR with random idle gaps
        do_reset(3'd0);
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_deal(3'd0, 1'b0, 1'b0);
        end

        // Random mix of the deterministic modes
        do_reset(3'd2);
        for (int k = 0; k < 50; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_deal(3'($urandom_range(1, 7)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
